// File: rtl/fpu_to_int.sv
// ============================================================================
// fpu_to_int
// ----------------------------------------------------------------------------
// Purpose:
//   Converts one 32-bit word from the FPU's float format to a signed OUT_W-bit
//   two's-complement integer. The float layout is sign[31], exp[30:25] and
//   mant[24:0], with an implicit leading 1, so the value is
//   (-1)^s * 1.mant * 2^(exp-BIAS).
//   The conversion uses a 1-bit-per-cycle shifter. A start/busy/done
//   handshake controls it. Bits shifted out to the right set a sticky flag,
//   and that flag reports the result as INEXACT.
//
// Ports:
//   clock100KHz  in   1      single clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      1-cycle request, ignored while busy=1
//   float_in     in   32     operand, sampled when start=1 && !busy
//   int_out      out  OUT_W  converted integer, held until the next done
//   status_out   out  4      one-hot: 0001 EXACT, 0010 INEXACT,
//                            0100 OVERFLOW, 1000 UNDERFLOW
//   busy         out  1      high from the cycle after acceptance through
//                            the done cycle
//   done         out  1      1-cycle pulse; int_out and status_out are valid
//                            from this cycle
//
// Only OUT_W = 32 is supported.
// ============================================================================
module fpu_to_int #(
    parameter int BIAS  = 31,
    parameter int OUT_W = 32
) (
    input  logic             clock100KHz,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      float_in,
    output logic [OUT_W-1:0] int_out,
    output logic [3:0]       status_out,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b0010;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
    localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        SHIFT,
        FINISH
    } state_t;

    state_t      state;
    logic        sign_q;
    logic [5:0]  exp_q;
    logic [31:0] mag;
    logic        sticky;
    logic        shift_left;
    logic [4:0]  shift_cnt;
    logic [3:0]  status_pre;
    logic        status_set;

    // Decode the unbiased exponent from the latched exp field.
    //
    // e_bits is 7 bits wide and is read as signed. The range is -31..32, so
    // bit 6 is the "less than one" flag.
    //
    // Shift distances are only used when 0 <= E <= 30. In that range 5-bit
    // modular arithmetic is exact.
    logic [6:0]  e_bits;
    logic        e_neg;
    logic        e_big;
    logic        mant_zero;
    logic [4:0]  n_right;
    logic [4:0]  n_left;

    always_comb begin
        e_bits    = {1'b0, exp_q} - 7'(BIAS);
        e_neg     = e_bits[6];
        e_big     = ($signed(e_bits) >= 7'sd31);
        mant_zero = (mag[24:0] == 25'd0);
        n_right   = 5'd25 - e_bits[4:0];
        n_left    = e_bits[4:0] - 5'd25;
    end

    // Conversion FSM with registered outputs.
    //
    // IDLE has two jobs. It clears busy one cycle after done, and it accepts
    // a new request. Because busy is still high in the done cycle, a start
    // asserted in that cycle is ignored.
    //
    // UNPACK handles the early-exit cases and loads the shift distance.
    // SHIFT moves the magnitude 1 bit per cycle.
    // FINISH applies the sign and publishes the result with a 1-cycle done.
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= 6'd0;
            mag        <= 32'd0;
            sticky     <= 1'b0;
            shift_left <= 1'b0;
            shift_cnt  <= 5'd0;
            status_pre <= 4'd0;
            status_set <= 1'b0;
            int_out    <= '0;
            status_out <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        sign_q     <= float_in[31];
                        exp_q      <= float_in[30:25];
                        mag        <= {6'd0, 1'b1, float_in[24:0]};
                        sticky     <= 1'b0;
                        status_pre <= 4'd0;
                        status_set <= 1'b0;
                        busy       <= 1'b1;
                        state      <= UNPACK;
                    end
                end

                UNPACK: begin
                    if (exp_q == 6'd0 && mant_zero) begin
                        mag        <= 32'd0;
                        status_pre <= ST_EXACT;
                        status_set <= 1'b1;
                        state      <= FINISH;
                    end else if (e_neg) begin
                        mag        <= 32'd0;
                        status_pre <= ST_UNDERFLOW;
                        status_set <= 1'b1;
                        state      <= FINISH;
                    end else if (e_big) begin
                        // The only representable value at or beyond 2^31
                        // is exactly -2^31.
                        if (e_bits == 7'd31 && mant_zero && sign_q) begin
                            mag        <= 32'h8000_0000;
                            status_pre <= ST_EXACT;
                        end else begin
                            mag        <= 32'd0;
                            status_pre <= ST_OVERFLOW;
                        end
                        status_set <= 1'b1;
                        state      <= FINISH;
                    end else if (e_bits[4:0] < 5'd25) begin
                        shift_left <= 1'b0;
                        shift_cnt  <= n_right;
                        state      <= SHIFT;
                    end else if (e_bits[4:0] > 5'd25) begin
                        shift_left <= 1'b1;
                        shift_cnt  <= n_left;
                        state      <= SHIFT;
                    end else begin
                        state <= FINISH;
                    end
                end

                SHIFT: begin
                    // Left shifts are at most 5 places here, so the top bit
                    // never leaves the register.
                    if (shift_left) begin
                        mag <= {mag[30:0], 1'b0};
                    end else begin
                        mag    <= {1'b0, mag[31:1]};
                        sticky <= sticky | mag[0];
                    end
                    shift_cnt <= shift_cnt - 5'd1;
                    if (shift_cnt == 5'd1) begin
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    // Negating zero gives zero, so -0 needs no special case.
                    int_out <= sign_q ? OUT_W'(-mag) : OUT_W'(mag);
                    if (status_set) begin
                        status_out <= status_pre;
                    end else begin
                        status_out <= sticky ? ST_INEXACT : ST_EXACT;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
